// File: rtl/router_pkt_tx_pkg.sv
// Shared types and header layout for the router packet transmitter.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HDR,
        PAY,
        PAR,
        CHECK
    } state_t;

    localparam int unsigned ADDR_LSB     = 0;
    localparam int unsigned LEN_LSB      = 2;
    localparam logic [1:0]  ADDR_ILLEGAL = 2'b11;
    localparam int unsigned MAX_LEN      = 63;

    function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
        logic [7:0] h;
        h                 = '0;
        h[ADDR_LSB +: 2]  = addr;
        h[LEN_LSB +: 6]   = len;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Byte link between the packet transmitter and the router input port.
interface router_pkt_tx_if;

    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       busy;
    logic       err;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output busy,
        output err
    );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// Payload store: register array with synchronous write, combinational read,
// and a write pointer that is cleared when a new command is accepted.
module router_tx_buf #(
    parameter int unsigned DEPTH = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] wr_ptr
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (wr_clr) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 6'd1;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input port: buffers a
// command's payload, then sends header, payload and parity back to back.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned BUSY_TIMEOUT = 1023,
    parameter int unsigned ERR_WAIT     = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_addr,
    input  logic [5:0]             cmd_len,
    input  logic                   cmd_bad_par,
    input  logic                   pl_valid,
    output logic                   pl_ready,
    input  logic [7:0]             pl_data,
    router_pkt_tx_if.master        link,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic                   cmd_rej,
    output logic                   busy_to
);

    localparam int unsigned BW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned EW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [BW-1:0] TO_MAX  = BW'(BUSY_TIMEOUT);
    localparam logic [BW-1:0] TO_LAST = BW'(BUSY_TIMEOUT - 1);
    localparam logic [EW-1:0] CHK_LAST = EW'(ERR_WAIT - 1);

    state_t        state;
    logic [1:0]    addr;
    logic [5:0]    len;
    logic          bad_par;
    logic [7:0]    parity;
    logic [5:0]    rd;
    logic [BW-1:0] busy_cnt;
    logic [EW-1:0] chk_cnt;
    logic          err_flag;

    logic [5:0]    wr_ptr;
    logic [5:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          cmd_ok;
    logic          cmd_take;
    logic          pl_take;
    logic          sending;

    assign cmd_ready = (state == IDLE);
    assign pl_ready  = (state == FILL);
    assign cmd_ok    = (cmd_addr != ADDR_ILLEGAL) && (cmd_len != '0);
    assign cmd_take  = cmd_ready && cmd_valid && cmd_ok;
    assign pl_take   = pl_ready && pl_valid;
    assign sending   = (state == HDR) || (state == PAY) || (state == PAR);
    // Read one entry ahead so the next byte is ready on the transfer edge.
    assign rd_addr   = (state == HDR) ? '0 : rd + 6'd1;

    router_tx_buf #(.DEPTH(DEPTH)) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_clr  (cmd_take),
        .wr_en   (pl_take),
        .wr_data (pl_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            addr           <= '0;
            len            <= '0;
            bad_par        <= 1'b0;
            parity         <= '0;
            rd             <= '0;
            chk_cnt        <= '0;
            err_flag       <= 1'b0;
            link.pkt_data  <= '0;
            link.pkt_valid <= 1'b0;
            tx_done        <= 1'b0;
            tx_err         <= 1'b0;
            cmd_rej        <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            cmd_rej <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_ok) begin
                            cmd_rej <= 1'b1;
                        end else begin
                            addr    <= cmd_addr;
                            len     <= cmd_len;
                            bad_par <= cmd_bad_par;
                            parity  <= make_header(cmd_addr, cmd_len);
                            state   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (pl_take) begin
                        parity <= parity ^ pl_data;
                        if (wr_ptr == len - 6'd1) begin
                            link.pkt_valid <= 1'b1;
                            link.pkt_data  <= make_header(addr, len);
                            state          <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (!link.busy) begin
                        link.pkt_data <= rd_data;
                        rd            <= '0;
                        state         <= PAY;
                    end
                end
                PAY: begin
                    if (!link.busy) begin
                        if (rd == len - 6'd1) begin
                            link.pkt_valid <= 1'b0;
                            link.pkt_data  <= parity ^ {8{bad_par}};
                            state          <= PAR;
                        end else begin
                            link.pkt_data <= rd_data;
                            rd            <= rd + 6'd1;
                        end
                    end
                end
                PAR: begin
                    if (!link.busy) begin
                        link.pkt_data <= '0;
                        err_flag      <= 1'b0;
                        chk_cnt       <= '0;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    err_flag <= err_flag | link.err;
                    if (chk_cnt == CHK_LAST) begin
                        tx_done <= 1'b1;
                        tx_err  <= err_flag | link.err;
                        state   <= IDLE;
                    end else begin
                        chk_cnt <= chk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall watchdog: flags a stuck router but never aborts the packet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= '0;
            busy_to  <= 1'b0;
        end else begin
            if (cmd_take) begin
                busy_to <= 1'b0;
            end
            if (sending && link.busy) begin
                if (busy_cnt != TO_MAX) begin
                    busy_cnt <= busy_cnt + 1'b1;
                end
                if (busy_cnt == TO_LAST) begin
                    busy_to <= 1'b1;
                end
            end else begin
                busy_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized bench for router_pkt_tx with a queue-based wire model.
module tb_router_pkt_tx;

    localparam int unsigned DEPTH        = 64;
    localparam int unsigned BUSY_TIMEOUT = 1023;
    localparam int unsigned ERR_WAIT     = 3;

    logic       clock;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_bad_par;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       tx_done;
    logic       tx_err;
    logic       cmd_rej;
    logic       busy_to;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl_bytes [64];

    router_pkt_tx_if link ();

    router_pkt_tx #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .ERR_WAIT     (ERR_WAIT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_bad_par (cmd_bad_par),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_data     (pl_data),
        .link        (link),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .cmd_rej     (cmd_rej),
        .busy_to     (busy_to)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer a command, then stream its payload with random pl_valid gaps.
    task automatic issue_cmd_fill(input logic [1:0] a, input logic [5:0] l, input logic bp);
        int i;
        int cyc;
        @(negedge clock);
        check1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_addr    = a;
        cmd_len     = l;
        cmd_bad_par = bp;
        @(negedge clock);
        cmd_valid   = 1'b0;
        cmd_bad_par = 1'b0;
        check1("cmd_rej_legal", cmd_rej, 1'b0);
        i   = 0;
        cyc = 0;
        while (i < int'(l) && cyc < 500) begin
            if (pl_ready && $urandom_range(0, 3) != 0) begin
                pl_valid = 1'b1;
                pl_data  = pl_bytes[i];
                i++;
            end else begin
                pl_valid = 1'b0;
                pl_data  = 8'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        pl_valid = 1'b0;
        checki("fill_count", i, int'(l));
        check1("pl_ready_drop", pl_ready, 1'b0);
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 five-cycle stall on byte 22.
    task automatic run_packet(input logic [1:0] a, input logic [5:0] l, input logic bp,
                              input int busy_mode, input logic inj_err);
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        logic [7:0] par;
        logic       prev_hold;
        logic [7:0] prev_pd;
        logic       prev_pv;
        int         stall_left;
        int         cyc;

        par = {l, a};
        exp_q.push_back(par);
        for (int k = 0; k < int'(l); k++) begin
            exp_q.push_back(pl_bytes[k]);
            par = par ^ pl_bytes[k];
        end
        if (bp) par = ~par;
        exp_q.push_back(par);

        issue_cmd_fill(a, l, bp);

        prev_hold  = 1'b0;
        prev_pd    = '0;
        prev_pv    = 1'b0;
        stall_left = (busy_mode == 2) ? 5 : 0;
        cyc        = 0;
        while (got_q.size() < int'(l) + 2 && cyc < 3000) begin
            if (prev_hold) begin
                check8("hold_data", link.pkt_data, prev_pd);
                check1("hold_valid", link.pkt_valid, prev_pv);
            end
            case (busy_mode)
                0: link.busy = 1'b0;
                1: link.busy = ($urandom_range(0, 2) == 0);
                default: begin
                    if (link.pkt_valid && link.pkt_data == 8'h22 && stall_left > 0) begin
                        link.busy = 1'b1;
                        stall_left--;
                    end else begin
                        link.busy = 1'b0;
                    end
                end
            endcase
            if (!link.busy) begin
                check1("wire_valid", link.pkt_valid, (got_q.size() < int'(l) + 1));
                got_q.push_back(link.pkt_data);
            end
            prev_hold = link.busy;
            prev_pd   = link.pkt_data;
            prev_pv   = link.pkt_valid;
            @(negedge clock);
            cyc++;
        end
        link.busy = 1'b0;
        link.err  = inj_err;

        if (busy_mode == 2) checki("stall_used", stall_left, 0);
        checki("wire_len", got_q.size(), int'(l) + 2);
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check8($sformatf("wire_byte%0d", k), got_q[k], exp_q[k]);
        end
        check1("after_par_valid", link.pkt_valid, 1'b0);
        check8("after_par_data", link.pkt_data, 8'h00);

        cyc = 0;
        while (!tx_done && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check1("tx_done_seen", tx_done, 1'b1);
        check1("tx_err", tx_err, inj_err);
        check1("idle_after_done", cmd_ready, 1'b1);
        link.err = 1'b0;
        @(negedge clock);
        check1("tx_done_pulse", tx_done, 1'b0);
    endtask

    task automatic illegal_cmd(input logic [1:0] a, input logic [5:0] l);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clock);
        cmd_valid = 1'b0;
        check1("rej_pulse", cmd_rej, 1'b1);
        check1("rej_cmd_ready", cmd_ready, 1'b1);
        check1("rej_pl_ready", pl_ready, 1'b0);
        check1("rej_pkt_valid", link.pkt_valid, 1'b0);
        @(negedge clock);
        check1("rej_pulse_end", cmd_rej, 1'b0);
        check1("rej_pl_ready2", pl_ready, 1'b0);
        check1("rej_pkt_valid2", link.pkt_valid, 1'b0);
    endtask

    initial begin
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        cmd_bad_par = 1'b0;
        pl_valid    = 1'b0;
        pl_data     = '0;
        link.busy   = 1'b0;
        link.err    = 1'b0;

        #12;
        check8("rst_pkt_data", link.pkt_data, 8'h00);
        check1("rst_pkt_valid", link.pkt_valid, 1'b0);
        check1("rst_tx_done", tx_done, 1'b0);
        check1("rst_tx_err", tx_err, 1'b0);
        check1("rst_cmd_rej", cmd_rej, 1'b0);
        check1("rst_busy_to", busy_to, 1'b0);
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_pl_ready", pl_ready, 1'b0);
        @(negedge clock);
        resetn = 1'b1;

        pl_bytes[0] = 8'h11;
        pl_bytes[1] = 8'h22;
        pl_bytes[2] = 8'h33;
        run_packet(2'd1, 6'd3, 1'b0, 0, 1'b0);
        run_packet(2'd1, 6'd3, 1'b0, 2, 1'b0);

        illegal_cmd(2'd3, 6'd4);
        illegal_cmd(2'd0, 6'd0);

        pl_bytes[0] = 8'hAA;
        run_packet(2'd2, 6'd1, 1'b1, 0, 1'b1);

        for (int p = 0; p < 4; p++) begin
            logic [5:0] l;
            l = 6'($urandom_range(1, 20));
            for (int k = 0; k < 64; k++) pl_bytes[k] = 8'($urandom);
            run_packet(2'($urandom_range(0, 2)), l, 1'($urandom), 1, 1'($urandom));
        end

        for (int k = 0; k < 63; k++) pl_bytes[k] = 8'(k);
        run_packet(2'd0, 6'd63, 1'b0, 1, 1'b0);

        pl_bytes[0] = 8'h5A;
        pl_bytes[1] = 8'hC3;
        issue_cmd_fill(2'd1, 6'd2, 1'b0);
        check1("to_hdr_valid", link.pkt_valid, 1'b1);
        link.busy = 1'b1;
        repeat (BUSY_TIMEOUT - 1) @(negedge clock);
        check1("busy_to_before", busy_to, 1'b0);
        @(negedge clock);
        check1("busy_to_set", busy_to, 1'b1);
        check8("to_hold_hdr", link.pkt_data, 8'h09);
        check1("to_hold_valid", link.pkt_valid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check1("mid_rst_pkt_valid", link.pkt_valid, 1'b0);
        check1("mid_rst_busy_to", busy_to, 1'b0);
        check1("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check1("mid_rst_pl_ready", pl_ready, 1'b0);
        link.busy = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        pl_bytes[0] = 8'h7E;
        run_packet(2'd2, 6'd1, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
